// File: rtl/cla_pipelined_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Stage 1 registers bit and group propagate/generate; stage 2 resolves carries and flags.
module cla_pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG = WIDTH / GROUP;

  if ((WIDTH % GROUP) != 0) begin : g_bad_width
    $error("cla_pipelined_adder: WIDTH must be a multiple of GROUP");
  end
  if ((GROUP != 2) && (GROUP != 4) && (GROUP != 8)) begin : g_bad_group
    $error("cla_pipelined_adder: GROUP must be 2, 4 or 8");
  end

  // stage 1 combinational terms
  logic [WIDTH-1:0] b_eff_s;
  logic             c0_s;
  logic [WIDTH-1:0] p_s;
  logic [WIDTH-1:0] g_s;
  logic [NG-1:0]    gp_s;
  logic [NG-1:0]    gg_s;

  // stage 1 registers
  logic [WIDTH-1:0] p_d, p_q;
  logic [WIDTH-1:0] g_d, g_q;
  logic [NG-1:0]    gp_d, gp_q;
  logic [NG-1:0]    gg_d, gg_q;
  logic             c0_d, c0_q;
  logic             a_msb_d, a_msb_q;
  logic             b_msb_d, b_msb_q;
  logic             s1_valid_d, s1_valid_q;
  logic             ready_en_d, ready_en_q;

  // stage 2 combinational terms
  logic [NG:0]      gc_s;
  logic [WIDTH-1:0] c_s;
  logic [WIDTH-1:0] sum_s;
  logic             cout_s;
  logic             ovf_s;
  logic             zero_s;

  // output registers
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;
  logic             zero_d, zero_q;
  logic             out_valid_d, out_valid_q;

  logic             adv2_s;
  logic             accept_s;

  // Handshake: stage 2 advances when the output slot is empty or being drained.
  always_comb begin
    adv2_s   = s1_valid_q & (~out_valid_q | out_ready);
    in_ready = ready_en_q & (~s1_valid_q | adv2_s);
    accept_s = in_valid & in_ready;
  end

  // Operand transform, bit p/g and flat per-group P/G.
  always_comb begin
    logic term;
    b_eff_s = sub ? ~b : b;
    c0_s    = sub ? 1'b1 : cin;
    p_s     = a ^ b_eff_s;
    g_s     = a & b_eff_s;
    gp_s    = {NG{1'b0}};
    gg_s    = {NG{1'b0}};
    term    = 1'b0;
    for (int k = 0; k < NG; k++) begin
      gp_s[k] = &p_s[k*GROUP +: GROUP];
      for (int j = 0; j < GROUP; j++) begin
        term = g_s[k*GROUP + j];
        for (int m = j + 1; m < GROUP; m++) begin
          term = term & p_s[k*GROUP + m];
        end
        gg_s[k] = gg_s[k] | term;
      end
    end
  end

  // Stage 1 next state: load on accept, drain on advance, otherwise hold.
  always_comb begin
    ready_en_d = 1'b1;
    if (accept_s) begin
      p_d        = p_s;
      g_d        = g_s;
      gp_d       = gp_s;
      gg_d       = gg_s;
      c0_d       = c0_s;
      a_msb_d    = a[WIDTH-1];
      b_msb_d    = b_eff_s[WIDTH-1];
      s1_valid_d = 1'b1;
    end else begin
      p_d        = p_q;
      g_d        = g_q;
      gp_d       = gp_q;
      gg_d       = gg_q;
      c0_d       = c0_q;
      a_msb_d    = a_msb_q;
      b_msb_d    = b_msb_q;
      s1_valid_d = adv2_s ? 1'b0 : s1_valid_q;
    end
  end

  // Stage 1 register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q        <= {WIDTH{1'b0}};
      g_q        <= {WIDTH{1'b0}};
      gp_q       <= {NG{1'b0}};
      gg_q       <= {NG{1'b0}};
      c0_q       <= 1'b0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      p_q        <= p_d;
      g_q        <= g_d;
      gp_q       <= gp_d;
      gg_q       <= gg_d;
      c0_q       <= c0_d;
      a_msb_q    <= a_msb_d;
      b_msb_q    <= b_msb_d;
      s1_valid_q <= s1_valid_d;
      ready_en_q <= ready_en_d;
    end
  end

  // Group carries as a two-level sum of products, then ripple inside each group.
  always_comb begin
    logic term;
    logic acc;
    logic c;
    gc_s    = {(NG+1){1'b0}};
    c_s     = {WIDTH{1'b0}};
    term    = 1'b0;
    acc     = 1'b0;
    c       = 1'b0;
    gc_s[0] = c0_q;
    for (int k = 0; k < NG; k++) begin
      term = c0_q;
      for (int m = 0; m <= k; m++) begin
        term = term & gp_q[m];
      end
      acc = term;
      for (int m = 0; m <= k; m++) begin
        term = gg_q[m];
        for (int n = m + 1; n <= k; n++) begin
          term = term & gp_q[n];
        end
        acc = acc | term;
      end
      gc_s[k+1] = acc;
    end
    for (int k = 0; k < NG; k++) begin
      c = gc_s[k];
      for (int j = 0; j < GROUP; j++) begin
        c_s[k*GROUP + j] = c;
        c = g_q[k*GROUP + j] | (p_q[k*GROUP + j] & c);
      end
    end
    sum_s  = p_q ^ c_s;
    cout_s = gc_s[NG];
    ovf_s  = (a_msb_q == b_msb_q) & (sum_s[WIDTH-1] != a_msb_q);
    zero_s = ~|sum_s;
  end

  // Output stage next state: capture on advance, clear valid once popped.
  always_comb begin
    if (adv2_s) begin
      sum_d       = sum_s;
      cout_d      = cout_s;
      ovf_d       = ovf_s;
      zero_d      = zero_s;
      out_valid_d = 1'b1;
    end else begin
      sum_d       = sum_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      zero_d      = zero_q;
      out_valid_d = out_ready ? 1'b0 : out_valid_q;
    end
  end

  // Output register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= {WIDTH{1'b0}};
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;

endmodule
